// File: rtl/fp32_mul_pipe_pkg.sv
// Shared binary32 constants, rounding-mode encoding and field layout for the
// pipelined single-precision multiplier.
package fp32_mul_pipe_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;
    localparam int MANT_W = FRAC_W + 1;
    localparam int PROD_W = 2 * MANT_W;

    typedef enum logic [2:0] {
        RM_RTE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG   = 31'h7F80_0000;
    localparam logic [30:0] MAX_MAG   = 31'h7F7F_FFFF;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Unassigned codes 101..111 fall back to round-to-nearest-even.
    function automatic rm_e decode_rm(input logic [2:0] code);
        case (code)
            3'b001:  decode_rm = RM_RTZ;
            3'b010:  decode_rm = RM_RDN;
            3'b011:  decode_rm = RM_RUP;
            3'b100:  decode_rm = RM_RMM;
            default: decode_rm = RM_RTE;
        endcase
    endfunction

endpackage

// File: rtl/fp32_mul_pipe_mul_u24.sv
// 24x24 -> 48 unsigned combinational significand multiplier.
module mul_u24 (
    input  logic [23:0] a,
    input  logic [23:0] b,
    output logic [47:0] p
);

    assign p = a * b;

endmodule

// File: rtl/fp32_mul_pipe.sv
// IEEE-754 binary32 multiplier, 4 enabled cycles from operands to result/nv/of.
// Define MUL_FP32_FTZ_EN to flush subnormal inputs and tiny results to signed zero.
module fp32_mul_pipe
    import fp32_mul_pipe_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic [2:0]  rm,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] result,
    output logic        nv,
    output logic        of
);

    if (LATENCY != 4) begin : g_latency_check
        $error("fp32_mul_pipe only supports LATENCY = 4");
    end

    function automatic logic round_inc(input rm_e mode, input logic sign, input logic lsb,
                                       input logic guard, input logic sticky);
        case (mode)
            RM_RTZ:  round_inc = 1'b0;
            RM_RDN:  round_inc = sign & (guard | sticky);
            RM_RUP:  round_inc = ~sign & (guard | sticky);
            RM_RMM:  round_inc = guard;
            default: round_inc = guard & (sticky | lsb);
        endcase
    endfunction

    function automatic logic [31:0] overflow_value(input rm_e mode, input logic sign);
        logic to_inf;
        case (mode)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = sign;
            RM_RUP:  to_inf = ~sign;
            default: to_inf = 1'b1;
        endcase
        overflow_value = {sign, to_inf ? INF_MAG : MAX_MAG};
    endfunction

    function automatic logic [5:0] lead_one(input logic [PROD_W-1:0] v);
        lead_one = '0;
        for (int i = 0; i < PROD_W; i++) begin
            if (v[i]) lead_one = 6'(i);
        end
    endfunction

    // d1: unpack, classify, special-case decision
    fp32_t a_c, b_c;
    logic  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic  sign_c, spec_c, spec_nv_c;
    logic  [31:0] spec_res_c;

    assign a_c = src1;
    assign b_c = src2;

`ifdef MUL_FP32_FTZ_EN
    assign a_zero = (a_c.exp == '0);
    assign b_zero = (b_c.exp == '0);
`else
    assign a_zero = (a_c.exp == '0) && (a_c.frac == '0);
    assign b_zero = (b_c.exp == '0) && (b_c.frac == '0);
`endif
    assign a_inf  = (a_c.exp == '1) && (a_c.frac == '0);
    assign b_inf  = (b_c.exp == '1) && (b_c.frac == '0);
    assign a_nan  = (a_c.exp == '1) && (a_c.frac != '0);
    assign b_nan  = (b_c.exp == '1) && (b_c.frac != '0);
    assign a_snan = a_nan && !a_c.frac[FRAC_W-1];
    assign b_snan = b_nan && !b_c.frac[FRAC_W-1];
    assign sign_c = a_c.sign ^ b_c.sign;

    always_comb begin
        spec_c     = 1'b1;
        spec_nv_c  = 1'b0;
        spec_res_c = CANON_NAN;
        if (a_snan || b_snan) begin
            spec_nv_c = 1'b1;
        end else if (a_nan || b_nan) begin
            spec_nv_c = 1'b0;
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            spec_nv_c = 1'b1;
        end else if (a_inf || b_inf) begin
            spec_res_c = {sign_c, INF_MAG};
        end else if (a_zero || b_zero) begin
            spec_res_c = {sign_c, 31'd0};
        end else begin
            spec_c = 1'b0;
        end
    end

    logic              sign_p1, spec_p1, spec_nv_p1;
    logic [31:0]       spec_res_p1;
    logic [MANT_W-1:0] mant_a_p1, mant_b_p1;
    logic [EXP_W-1:0]  exp_a_p1, exp_b_p1;
    rm_e               rm_p1;

    // Subnormals carry exponent 1 with a clear hidden bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            sign_p1     <= 1'b0;
            spec_p1     <= 1'b0;
            spec_nv_p1  <= 1'b0;
            spec_res_p1 <= '0;
            mant_a_p1   <= '0;
            mant_b_p1   <= '0;
            exp_a_p1    <= '0;
            exp_b_p1    <= '0;
            rm_p1       <= RM_RTE;
        end else if (en) begin
            sign_p1     <= sign_c;
            spec_p1     <= spec_c;
            spec_nv_p1  <= spec_nv_c;
            spec_res_p1 <= spec_res_c;
            mant_a_p1   <= {a_c.exp != '0, a_c.frac};
            mant_b_p1   <= {b_c.exp != '0, b_c.frac};
            exp_a_p1    <= (a_c.exp == '0) ? EXP_W'(1) : a_c.exp;
            exp_b_p1    <= (b_c.exp == '0) ? EXP_W'(1) : b_c.exp;
            rm_p1       <= decode_rm(rm);
        end
    end

    // d2: significand product and biased exponent sum
    logic [PROD_W-1:0] prod_c;
    logic signed [9:0] exp_sum_c;

    mul_u24 u_mul (
        .a(mant_a_p1),
        .b(mant_b_p1),
        .p(prod_c)
    );

    assign exp_sum_c = signed'({2'b00, exp_a_p1}) + signed'({2'b00, exp_b_p1})
                     - signed'(10'(BIAS));

    logic              sign_p2, spec_p2, spec_nv_p2;
    logic [31:0]       spec_res_p2;
    logic [PROD_W-1:0] prod_p2;
    logic signed [9:0] exp_p2;
    rm_e               rm_p2;

    always_ff @(posedge clock) begin
        if (reset) begin
            sign_p2     <= 1'b0;
            spec_p2     <= 1'b0;
            spec_nv_p2  <= 1'b0;
            spec_res_p2 <= '0;
            prod_p2     <= '0;
            exp_p2      <= '0;
            rm_p2       <= RM_RTE;
        end else if (en) begin
            sign_p2     <= sign_p1;
            spec_p2     <= spec_p1;
            spec_nv_p2  <= spec_nv_p1;
            spec_res_p2 <= spec_res_p1;
            prod_p2     <= prod_c;
            exp_p2      <= exp_sum_c;
            rm_p2       <= rm_p1;
        end
    end

    // d3: normalize (and denormalize), extract guard/sticky
    logic [5:0]          lo_c;
    logic [PROD_W-2:0]   norm_c;
    logic signed [9:0]   exp_n_c, exp_d_c;
    logic [FRAC_W-1:0]   frac_c;
    logic                guard_c, sticky_c;

    // norm_c holds the bits below the leading one, which is implicit from here on.
    assign lo_c    = lead_one(prod_p2);
    assign norm_c  = (PROD_W-1)'(prod_p2 << (6'd47 - lo_c));
    assign exp_n_c = exp_p2 + signed'({4'd0, lo_c}) - 10'sd46;

`ifdef MUL_FP32_FTZ_EN
    always_comb begin
        frac_c   = norm_c[46:24];
        guard_c  = norm_c[23];
        sticky_c = |norm_c[22:0];
        exp_d_c  = exp_n_c;
    end
`else
    logic signed [9:0] dsh_s;
    logic [6:0]        dsh_c;
    logic [94:0]       wide_c;

    // A shift of 72 already moves every product bit below the guard position.
    always_comb begin
        dsh_s  = 10'sd1 - exp_n_c;
        dsh_c  = (dsh_s > 10'sd72) ? 7'd72 : dsh_s[6:0];
        wide_c = 95'({1'b1, norm_c, 48'd0} >> dsh_c);
        if (exp_n_c > 10'sd0) begin
            frac_c   = norm_c[46:24];
            guard_c  = norm_c[23];
            sticky_c = |norm_c[22:0];
            exp_d_c  = exp_n_c;
        end else begin
            frac_c   = wide_c[94:72];
            guard_c  = wide_c[71];
            sticky_c = |wide_c[70:0];
            exp_d_c  = '0;
        end
    end
`endif

    logic              sign_p3, spec_p3, spec_nv_p3, guard_p3, sticky_p3;
    logic [31:0]       spec_res_p3;
    logic [FRAC_W-1:0] frac_p3;
    logic signed [9:0] exp_p3;
    rm_e               rm_p3;

    always_ff @(posedge clock) begin
        if (reset) begin
            sign_p3     <= 1'b0;
            spec_p3     <= 1'b0;
            spec_nv_p3  <= 1'b0;
            spec_res_p3 <= '0;
            frac_p3     <= '0;
            guard_p3    <= 1'b0;
            sticky_p3   <= 1'b0;
            exp_p3      <= '0;
            rm_p3       <= RM_RTE;
        end else if (en) begin
            sign_p3     <= sign_p2;
            spec_p3     <= spec_p2;
            spec_nv_p3  <= spec_nv_p2;
            spec_res_p3 <= spec_res_p2;
            frac_p3     <= frac_c;
            guard_p3    <= guard_c;
            sticky_p3   <= sticky_c;
            exp_p3      <= exp_d_c;
            rm_p3       <= rm_p2;
        end
    end

    // d4: round, overflow select, pack
    logic              inc_c, of_c;
    logic [32:0]       rnd_c;
    logic signed [9:0] exp_r_c;
    logic [31:0]       res_c;

    // Adding the increment across {exp, frac} lets a rounding carry bump the
    // exponent, including subnormal -> smallest normal.
    assign inc_c   = round_inc(rm_p3, sign_p3, frac_p3[0], guard_p3, sticky_p3);
    assign rnd_c   = {exp_p3, frac_p3} + {32'd0, inc_c};
    assign exp_r_c = signed'(rnd_c[32:23]);
    assign of_c    = !spec_p3 && (exp_r_c >= 10'sd255);

    always_comb begin
        if (spec_p3) begin
            res_c = spec_res_p3;
        end else if (exp_r_c >= 10'sd255) begin
            res_c = overflow_value(rm_p3, sign_p3);
`ifdef MUL_FP32_FTZ_EN
        end else if (exp_r_c <= 10'sd0) begin
            res_c = {sign_p3, 31'd0};
`endif
        end else begin
            res_c = {sign_p3, exp_r_c[7:0], rnd_c[22:0]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            result <= '0;
            nv     <= 1'b0;
            of     <= 1'b0;
        end else if (en) begin
            result <= res_c;
            nv     <= spec_p3 && spec_nv_p3;
            of     <= of_c;
        end
    end

endmodule

// File: tb/tb_fp32_mul_pipe.sv
// Bench for fp32_mul_pipe: exact-arithmetic reference model behind a 4-deep
// enabled delay line, directed literal vectors, random operands with random en.
module tb_fp32_mul_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [2:0]  rm = 3'd0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic [31:0] result;
    logic        nv, of;

    fp32_mul_pipe #(.LATENCY(4)) dut (
        .clock (clock),
        .reset (reset),
        .en    (en),
        .rm    (rm),
        .src1  (src1),
        .src2  (src2),
        .result(result),
        .nv    (nv),
        .of    (of)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] r;
        logic        nv;
        logic        of;
    } res_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   chk_on   = 0;
    res_t pipe [4];

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got result=%h nv=%b of=%b, expected result=%h nv=%b of=%b",
                      name, act[33:2], act[1], act[0], want[33:2], want[1], want[0]);
    endtask

    // Exact product P * 2^e0, rounded onto the binary32 grid by integer division.
    function automatic res_t fp_model(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] rm_in);
        res_t o;
        int mode, ea, eb, xa, xb, e0, msb, x, q, sh, bexp;
        logic sg;
        logic [22:0] fa, fb;
        bit a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, up;
        longint unsigned ma, mb, p, n, rem, half;
        o    = '0;
        mode = (rm_in > 3'd4) ? 0 : int'(rm_in);
        sg   = a[31] ^ b[31];
        ea   = int'(a[30:23]);
        eb   = int'(b[30:23]);
        fa   = a[22:0];
        fb   = b[22:0];
`ifdef MUL_FP32_FTZ_EN
        if (ea == 0) fa = '0;
        if (eb == 0) fb = '0;
`endif
        a_nan  = (ea == 255) && (fa != 0);
        b_nan  = (eb == 255) && (fb != 0);
        a_snan = a_nan && !fa[22];
        b_snan = b_nan && !fb[22];
        a_inf  = (ea == 255) && (fa == 0);
        b_inf  = (eb == 255) && (fb == 0);
        a_zero = (ea == 0) && (fa == 0);
        b_zero = (eb == 0) && (fb == 0);
        if (a_snan || b_snan) begin o.r = 32'h7FC00000; o.nv = 1'b1; return o; end
        if (a_nan || b_nan) begin o.r = 32'h7FC00000; return o; end
        if ((a_inf && b_zero) || (a_zero && b_inf)) begin o.r = 32'h7FC00000; o.nv = 1'b1; return o; end
        if (a_inf || b_inf) begin o.r = {sg, 31'h7F800000}; return o; end
        if (a_zero || b_zero) begin o.r = {sg, 31'd0}; return o; end
        ma = (ea == 0) ? {41'd0, fa} : {41'd0, fa} + 64'd8388608;
        mb = (eb == 0) ? {41'd0, fb} : {41'd0, fb} + 64'd8388608;
        xa = (ea == 0) ? 1 : ea;
        xb = (eb == 0) ? 1 : eb;
        p  = ma * mb;
        e0 = xa + xb - 254 - 46;
        msb = 0;
        for (int i = 0; i < 48; i++) if (p[i]) msb = i;
        x = msb + e0;
`ifdef MUL_FP32_FTZ_EN
        q = x - 23;
`else
        q = (x < -126) ? -149 : x - 23;
`endif
        sh = q - e0;
        if (sh <= 0) begin
            n = p << (-sh); rem = 0; half = 1;
        end else if (sh >= 50) begin
            // whole product lies strictly below half an ulp
            n = 0; rem = 1; half = 2;
        end else begin
            n = p >> sh; rem = p & ((64'd1 << sh) - 1); half = 64'd1 << (sh - 1);
        end
        case (mode)
            0:       up = (rem > half) || (rem == half && n[0]);
            1:       up = 0;
            2:       up = sg && (rem != 0);
            3:       up = !sg && (rem != 0);
            default: up = (rem >= half);
        endcase
        n = n + (up ? 64'd1 : 64'd0);
        if (n == (64'd1 << 24)) begin n = 64'd1 << 23; q++; end
        bexp = (n >= (64'd1 << 23)) ? q + 150 : 0;
        if (bexp >= 255) begin
            o.of = 1'b1;
            case (mode)
                1:       o.r = {sg, 31'h7F7FFFFF};
                2:       o.r = sg ? 32'hFF800000 : 32'h7F7FFFFF;
                3:       o.r = sg ? 32'hFF7FFFFF : 32'h7F800000;
                default: o.r = {sg, 31'h7F800000};
            endcase
`ifdef MUL_FP32_FTZ_EN
        end else if (bexp <= 0) begin
            o.r = {sg, 31'd0};
`endif
        end else begin
            o.r = {sg, 8'(bexp), n[22:0]};
        end
        return o;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) pipe[i] = '0;
        end else if (en) begin
            pipe[3] = pipe[2];
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = fp_model(src1, src2, rm);
        end
    end

    always @(negedge clock) begin
        if (chk_on) check("pipe", {result, nv, of}, pipe[3]);
    end

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom();
        case ($urandom_range(0, 9))
            0: v[30:23] = 8'($urandom_range(0, 3));
            1: v[30:23] = 8'($urandom_range(250, 255));
            2: v[30:23] = 8'($urandom_range(40, 70));
            3: v[30:23] = 8'($urandom_range(118, 136));
            4: v[30:23] = 8'($urandom_range(185, 200));
            5: begin
                case ($urandom_range(0, 11))
                    0:  v[30:0] = 31'h00000000;
                    1:  v[30:0] = 31'h7F800000;
                    2:  v[30:0] = 31'h7FC00000;
                    3:  v[30:0] = 31'h7F800001;
                    4:  v[30:0] = 31'h7FA00000;
                    5:  v[30:0] = 31'h00000001;
                    6:  v[30:0] = 31'h007FFFFF;
                    7:  v[30:0] = 31'h00800000;
                    8:  v[30:0] = 31'h3F800000;
                    9:  v[30:0] = 31'h7F7FFFFF;
                    10: v[30:0] = 31'h3F000000;
                    default: v[30:0] = 31'h3F800001;
                endcase
            end
            6: v[22:0] = 23'($urandom_range(0, 3));
            default: ;
        endcase
        return v;
    endfunction

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  m;
        logic [33:0] want;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    // Inputs are applied #1 after an edge; result appears after the 4th enabled edge.
    task automatic run_vec(input int idx);
        src1 = vecs[idx].a;
        src2 = vecs[idx].b;
        rm   = vecs[idx].m;
        en   = 1'b1;
        @(posedge clock);
        #1;
        src1 = '0;
        src2 = '0;
        rm   = 3'd0;
        repeat (3) @(posedge clock);
        #1;
        check($sformatf("dut_vec%0d", idx), {result, nv, of}, vecs[idx].want);
    endtask

    initial begin
        vecs[0]  = '{32'h3F800000, 32'h40000000, 3'd0, {32'h40000000, 2'b00}};
        vecs[1]  = '{32'h00000000, 32'h7F800000, 3'd0, {32'h7FC00000, 2'b10}};
        vecs[2]  = '{32'hFF800000, 32'h40000000, 3'd0, {32'hFF800000, 2'b00}};
        vecs[3]  = '{32'h80000000, 32'h3F800000, 3'd0, {32'h80000000, 2'b00}};
        vecs[4]  = '{32'h7F800001, 32'h3F800000, 3'd0, {32'h7FC00000, 2'b10}};
        vecs[5]  = '{32'h7FC00000, 32'h3F800000, 3'd0, {32'h7FC00000, 2'b00}};
        vecs[6]  = '{32'h7F7FFFFF, 32'h40000000, 3'd0, {32'h7F800000, 2'b01}};
        vecs[7]  = '{32'h7F7FFFFF, 32'h40000000, 3'd1, {32'h7F7FFFFF, 2'b01}};
        vecs[8]  = '{32'hFF7FFFFF, 32'h40000000, 3'd3, {32'hFF7FFFFF, 2'b01}};
        vecs[9]  = '{32'h3F800001, 32'h3F800001, 3'd0, {32'h3F800002, 2'b00}};
        vecs[10] = '{32'h3F800001, 32'h3F800001, 3'd3, {32'h3F800003, 2'b00}};
        vecs[11] = '{32'h3F800001, 32'h3F800001, 3'd1, {32'h3F800002, 2'b00}};
        vecs[12] = '{32'h3F800001, 32'h3F800001, 3'd7, {32'h3F800002, 2'b00}};
        vecs[13] = '{32'h7F7FFFFF, 32'h40000000, 3'd2, {32'h7F7FFFFF, 2'b01}};
        vecs[14] = '{32'hFF7FFFFF, 32'h40000000, 3'd2, {32'hFF800000, 2'b01}};
`ifdef MUL_FP32_FTZ_EN
        vecs[15] = '{32'h00800000, 32'h3F000000, 3'd0, {32'h00000000, 2'b00}};
        vecs[16] = '{32'h00000001, 32'h3F000000, 3'd4, {32'h00000000, 2'b00}};
        vecs[17] = '{32'h80000001, 32'h3F000000, 3'd2, {32'h80000000, 2'b00}};
`else
        vecs[15] = '{32'h00800000, 32'h3F000000, 3'd0, {32'h00400000, 2'b00}};
        vecs[16] = '{32'h00000001, 32'h3F000000, 3'd4, {32'h00000001, 2'b00}};
        vecs[17] = '{32'h80000001, 32'h3F000000, 3'd2, {32'h80000001, 2'b00}};
`endif

        for (int i = 0; i < NV; i++)
            check($sformatf("model_vec%0d", i), fp_model(vecs[i].a, vecs[i].b, vecs[i].m), vecs[i].want);
        check("model_rte_tie", fp_model(32'h00000001, 32'h3F000000, 3'd0), {32'h00000000, 2'b00});

        reset = 1'b1;
        @(posedge clock);
        #1 chk_on = 1'b1;
        @(posedge clock);
        #1;
        check("reset_state", {result, nv, of}, 34'd0);
        reset = 1'b0;

        // four enabled edges with an en=0 gap in the middle
        src1 = 32'h3F800000;
        src2 = 32'h40000000;
        rm   = 3'd0;
        en   = 1'b1;
        @(posedge clock);
        #1;
        src1 = '0;
        src2 = '0;
        en   = 1'b0;
        repeat (2) @(posedge clock);
        #1 en = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("lat_not_early", {32'(result == 32'h40000000), 2'b00}, 34'd0);
        @(posedge clock);
        #1;
        check("lat_4_enabled", {result, nv, of}, {32'h40000000, 2'b00});

        for (int i = 0; i < NV; i++) run_vec(i);

        for (int c = 0; c < 3000; c++) begin
            src1 = rand_op();
            src2 = rand_op();
            rm   = 3'($urandom_range(0, 7));
            en   = ($urandom_range(0, 3) != 0);
            if (c == 1500) begin
                src1  = 32'h3F800000;
                src2  = 32'h3F800000;
                en    = 1'b1;
                reset = 1'b1;
                @(posedge clock);
                #1;
                check("reset_mid", {result, nv, of}, 34'd0);
                reset = 1'b0;
            end else begin
                @(posedge clock);
                #1;
            end
        end

        en = 1'b1;
        repeat (5) @(posedge clock);
        #1 chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
